// File: rtl/decode_pkg.sv
// Shared constants for the instruction-decode stage: opcode values,
// instruction field offsets, one-hot class codes and buffer state encoding.
package decode_pkg;

    // Opcode values (instr[31:27])
    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    // Low bit of each 5-bit field
    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;

    // One-hot instruction class {jII, jI, i, r}
    localparam logic [3:0] CLS_NONE = 4'b0000;
    localparam logic [3:0] CLS_R    = 4'b0001;
    localparam logic [3:0] CLS_I    = 4'b0010;
    localparam logic [3:0] CLS_JI   = 4'b0100;
    localparam logic [3:0] CLS_JII  = 4'b1000;

    // Fixed link / status destinations
    localparam logic [4:0] RA      = 5'd31;
    localparam logic [4:0] RSTATUS = 5'd30;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/decode_if.sv
// Handshake and decoded-bundle signals between fetch, the decode stage and
// register-read. master = surrounding pipeline, slave = decode stage.
interface decode_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [4:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        shamt;
    logic [4:0]        alu_op;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] tgt_ext;
    logic [3:0]        cls;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic              illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd, rs, rt, shamt, alu_op,
               imm_ext, tgt_ext, cls, wr_en, wr_addr, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd, rs, rt, shamt, alu_op,
               imm_ext, tgt_ext, cls, wr_en, wr_addr, illegal
    );
endinterface

// File: rtl/decode_fields.sv
// Purely combinational instruction decoder: instr + pc -> decoded bundle.
// Optional macro DECODE_ILLEGAL_EN: flag undefined opcodes on illegal_o.
module decode_fields
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic [31:0]       instr_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [4:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        shamt_o,
    output logic [4:0]        alu_op_o,
    output logic [DATA_W-1:0] imm_ext_o,
    output logic [DATA_W-1:0] tgt_ext_o,
    output logic [3:0]        cls_o,
    output logic              wr_en_o,
    output logic [4:0]        wr_addr_o,
    output logic              illegal_o
);
    logic signed [16:0] imm_s;

    assign pc_o      = pc_i;
    assign opcode_o  = instr_i[OPC_LSB   +: 5];
    assign rd_o      = instr_i[RD_LSB    +: 5];
    assign rs_o      = instr_i[RS_LSB    +: 5];
    assign rt_o      = instr_i[RT_LSB    +: 5];
    assign shamt_o   = instr_i[SHAMT_LSB +: 5];
    assign alu_op_o  = instr_i[ALUOP_LSB +: 5];
    assign imm_s     = $signed(instr_i[16:0]);
    assign imm_ext_o = DATA_W'(imm_s);
    assign tgt_ext_o = DATA_W'(instr_i[26:0]);
    assign wr_en_o   = (wr_addr_o != 5'd0);

    // Classify the opcode and pick the effective writeback register
    always_comb begin
        cls_o     = CLS_NONE;
        wr_addr_o = 5'd0;
        case (opcode_o)
            OP_R:                  begin cls_o = CLS_R;  wr_addr_o = rd_o;    end
            OP_ADDI, OP_LW:        begin cls_o = CLS_I;  wr_addr_o = rd_o;    end
            OP_SW, OP_BNE, OP_BLT: begin cls_o = CLS_I;                       end
            OP_J, OP_BEX:          begin cls_o = CLS_JI;                      end
            OP_JAL:                begin cls_o = CLS_JI; wr_addr_o = RA;      end
            OP_SETX:               begin cls_o = CLS_JI; wr_addr_o = RSTATUS; end
            OP_JR:                 begin cls_o = CLS_JII;                     end
            default:               begin                                      end
        endcase
    end

`ifdef DECODE_ILLEGAL_EN
    assign illegal_o = (cls_o == CLS_NONE);
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on entry and holds decoded bundles in a
// 2-entry FIFO skid buffer so in_ready never depends on out_ready
// combinationally. Optional macro DECODE_ILLEGAL_EN (see decode_fields).
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input logic     clock,
    input logic     reset,
    input logic     flush,
    decode_if.slave bus
);
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [4:0]        opcode;
        logic [4:0]        rd;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        shamt;
        logic [4:0]        alu_op;
        logic [DATA_W-1:0] imm_ext;
        logic [DATA_W-1:0] tgt_ext;
        logic [3:0]        cls;
        logic              wr_en;
        logic [4:0]        wr_addr;
        logic              illegal;
    } entry_t;

    entry_t     dec_w, head_w;
    entry_t     slot0_q, slot0_d, slot1_q, slot1_d;
    buf_state_e state_q, state_d;
    logic       rdy_q, vld_q;
    logic       push, pop;

    decode_fields #(.DATA_W(DATA_W), .PC_W(PC_W)) u_fields (
        .instr_i   (bus.in_instr),
        .pc_i      (bus.in_pc),
        .pc_o      (dec_w.pc),
        .opcode_o  (dec_w.opcode),
        .rd_o      (dec_w.rd),
        .rs_o      (dec_w.rs),
        .rt_o      (dec_w.rt),
        .shamt_o   (dec_w.shamt),
        .alu_op_o  (dec_w.alu_op),
        .imm_ext_o (dec_w.imm_ext),
        .tgt_ext_o (dec_w.tgt_ext),
        .cls_o     (dec_w.cls),
        .wr_en_o   (dec_w.wr_en),
        .wr_addr_o (dec_w.wr_addr),
        .illegal_o (dec_w.illegal)
    );

    // Flush wins over both sides of the handshake in the same cycle
    assign push = bus.in_valid & rdy_q & ~flush;
    assign pop  = vld_q & bus.out_ready & ~flush;

    // Next occupancy and slot contents; slot0 is always the head entry
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    slot0_d = dec_w;
                    state_d = ONE;
                end
                ONE: begin
                    if (push && pop) begin
                        slot0_d = dec_w;
                    end else if (push) begin
                        slot1_d = dec_w;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    slot0_d = slot1_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Occupancy FSM with registered in_ready / out_valid
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != FULL);
            vld_q   <= (state_d != EMPTY);
        end
    end

    // Decoded-bundle storage; contents are don't-care while not occupied
    always_ff @(posedge clock) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    // Idle outputs read as zero
    assign head_w = vld_q ? slot0_q : '0;

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.out_pc    = head_w.pc;
    assign bus.opcode    = head_w.opcode;
    assign bus.rd        = head_w.rd;
    assign bus.rs        = head_w.rs;
    assign bus.rt        = head_w.rt;
    assign bus.shamt     = head_w.shamt;
    assign bus.alu_op    = head_w.alu_op;
    assign bus.imm_ext   = head_w.imm_ext;
    assign bus.tgt_ext   = head_w.tgt_ext;
    assign bus.cls       = head_w.cls;
    assign bus.wr_en     = head_w.wr_en;
    assign bus.wr_addr   = head_w.wr_addr;
    assign bus.illegal   = head_w.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand-written
// buffer corner sequences and a random run against a queue-based model.
module tb_decode_stage;
    import decode_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    always #5 clock = ~clock;

    decode_if #(.DATA_W(32), .PC_W(32)) bus ();

    decode_stage #(.DATA_W(32), .PC_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  alu_op;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic [3:0]  cls;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic        illegal;
    } bundle_t;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  cls;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic        undef;
    } vec_t;

    bundle_t q[$];
    bit      mrdy;
    bit      last_push;
    int      checks = 0;
    int      errors = 0;
    vec_t    vec[10];

    function automatic logic ill_exp(logic undef);
`ifdef DECODE_ILLEGAL_EN
        return undef;
`else
        return 1'b0;
`endif
    endfunction

    // Reference decode from the instruction-set rules
    function automatic bundle_t ref_decode(logic [31:0] ins, logic [31:0] pc);
        bundle_t b;
        int op;
        b = '0;
        b.pc     = pc;
        op       = int'(ins / 32'h0800_0000);
        b.opcode = 5'(op);
        b.rd     = 5'((ins / 32'h40_0000) % 32);
        b.rs     = 5'((ins / 32'h2_0000) % 32);
        b.rt     = 5'((ins / 32'h1000) % 32);
        b.shamt  = 5'((ins / 32'h80) % 32);
        b.alu_op = 5'((ins / 32'h4) % 32);
        b.imm    = ins % 32'h2_0000;
        if (b.imm >= 32'h1_0000) b.imm = b.imm - 32'h2_0000;
        b.tgt    = ins % 32'h0800_0000;
        case (op)
            0, 5, 8:   begin b.cls = 4'd1 << ((op == 0) ? 0 : 1); b.wr_addr = b.rd; end
            2, 6, 7:   b.cls = 4'd2;
            1, 22:     b.cls = 4'd4;
            3:         begin b.cls = 4'd4; b.wr_addr = 5'd31; end
            21:        begin b.cls = 4'd4; b.wr_addr = 5'd30; end
            4:         b.cls = 4'd8;
            default:   b.cls = 4'd0;
        endcase
        b.wr_en   = (b.wr_addr != 0);
        b.illegal = ill_exp(b.cls == 0);
        return b;
    endfunction

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b = '{bus.out_pc, bus.opcode, bus.rd, bus.rs, bus.rt, bus.shamt, bus.alu_op,
              bus.imm_ext, bus.tgt_ext, bus.cls, bus.wr_en, bus.wr_addr, bus.illegal};
        return b;
    endfunction

    task automatic check(string name, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare DUT against the model, then advance one clock and update model
    task automatic tick();
        bit er, ev, pop;
        bundle_t head, nw;
        er   = mrdy && (q.size() < 2);
        ev   = (q.size() > 0);
        head = ev ? q[0] : '0;
        check("in_ready", bus.in_ready, er);
        check("out_valid", bus.out_valid, ev);
        check("head_bundle", dut_bundle(), head);
        last_push = bus.in_valid && er && !flush && !reset;
        pop       = ev && bus.out_ready && !flush && !reset;
        nw        = ref_decode(bus.in_instr, bus.in_pc);
        @(posedge clock);
        if (reset) begin
            q.delete();
            mrdy = 1'b0;
        end else if (flush) begin
            q.delete();
            mrdy = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (last_push) q.push_back(nw);
            mrdy = 1'b1;
        end
        #1;
    endtask

    task automatic push_one(logic [31:0] ins, logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = pc;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (last_push) break;
        end
        bus.in_valid = 1'b0;
        if (!last_push) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no accept expected accept");
        end
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (q.size() == 0) break;
            tick();
        end
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] ops[12];
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22, 5'd31};
        return {ops[$urandom_range(0, 11)], 27'($urandom)};
    endfunction

    initial begin
        vec[0] = '{32'h28C3FFFF, 4'b0010, 32'hFFFFFFFF, 32'h00C3FFFF, 1'b1, 5'd3,  1'b0};
        vec[1] = '{32'h18000100, 4'b0100, 32'h00000100, 32'h00000100, 1'b1, 5'd31, 1'b0};
        vec[2] = '{32'h39400000, 4'b0010, 32'h00000000, 32'h01400000, 1'b0, 5'd0,  1'b0};
        vec[3] = '{32'h00020000, 4'b0001, 32'h00000000, 32'h00020000, 1'b0, 5'd0,  1'b0};
        vec[4] = '{32'h01C00000, 4'b0001, 32'h00000000, 32'h01C00000, 1'b1, 5'd7,  1'b0};
        vec[5] = '{32'h42400000, 4'b0010, 32'h00000000, 32'h02400000, 1'b1, 5'd9,  1'b0};
        vec[6] = '{32'hA8000005, 4'b0100, 32'h00000005, 32'h00000005, 1'b1, 5'd30, 1'b0};
        vec[7] = '{32'h20000000, 4'b1000, 32'h00000000, 32'h00000000, 1'b0, 5'd0,  1'b0};
        vec[8] = '{32'h10010000, 4'b0010, 32'hFFFF0000, 32'h00010000, 1'b0, 5'd0,  1'b0};
        vec[9] = '{32'hF8000000, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 5'd0,  1'b1};

        reset = 1'b1; flush = 1'b0; mrdy = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        @(posedge clock); #1;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Directed table: one instruction at a time, visible the next cycle
        bus.out_ready = 1'b1;
        foreach (vec[i]) begin
            push_one(vec[i].instr, 32'(i * 4));
            check("tbl_valid",   bus.out_valid, 1'b1);
            check("tbl_cls",     bus.cls,       vec[i].cls);
            check("tbl_imm",     bus.imm_ext,   vec[i].imm);
            check("tbl_tgt",     bus.tgt_ext,   vec[i].tgt);
            check("tbl_wr_en",   bus.wr_en,     vec[i].wr_en);
            check("tbl_wr_addr", bus.wr_addr,   vec[i].wr_addr);
            check("tbl_illegal", bus.illegal,   ill_exp(vec[i].undef));
            tick();
        end

        // Back-pressure: two accepted, third stalls, then FIFO release
        bus.out_ready = 1'b0;
        push_one(32'h28C3FFFF, 32'h100);
        push_one(32'h18000100, 32'h104);
        check("full_in_ready", bus.in_ready, 1'b0);
        check("full_head_pc",  bus.out_pc,   32'h100);
        bus.in_valid = 1'b1; bus.in_instr = 32'h39400000; bus.in_pc = 32'h108;
        tick();
        bus.out_ready = 1'b1;
        push_one(32'h39400000, 32'h108);
        drain();

        // Steady push&pop with one entry held
        push_one(32'h01C00000, 32'h200);
        for (int k = 0; k < 5; k++) begin
            check("pp_in_ready",  bus.in_ready,  1'b1);
            check("pp_out_valid", bus.out_valid, 1'b1);
            push_one(rand_instr(), 32'h204 + 32'(k * 4));
        end
        drain();

        // Flush while full, with a new instruction offered
        bus.out_ready = 1'b0;
        push_one(32'h42400000, 32'h300);
        push_one(32'hA8000005, 32'h304);
        flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h20000000;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_in_ready",  bus.in_ready,  1'b1);
        tick();

        // Reset with two entries buffered
        push_one(32'h28C3FFFF, 32'h400);
        push_one(32'h18000100, 32'h404);
        reset = 1'b1;
        tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready",  bus.in_ready,  1'b0);
        tick();
        reset = 1'b0;
        tick(); tick();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = $urandom_range(0, 1) == 1;
            flush         = ($urandom_range(0, 39) == 0);
            bus.in_instr  = rand_instr();
            bus.in_pc     = $urandom;
            tick();
        end
        flush = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
